rr_burst_arbiter: RTL
=====================

Name: rr_burst_arbiter

Overview:
- N-way round-robin arbiter with burst locking and a registered output stage.
- Shares one decoupled downstream channel between N decoupled requesters.
- Used where the existing combinational fixed-priority arbiter starves low-index ports or breaks up multi-beat transfers.
- The output register cuts the combinational ready/valid path between requesters and consumer.

Parameters:
- N_IN, 4, number of requesters (power of two, 2..16).
- W, 8, payload width in bits.
- CW, log2(N_IN), width of chosen index (derived, not overridable).

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- io_in_valid  in  N_IN  per-requester valid
- io_in_ready  out  N_IN  per-requester ready
- io_in_bits  in  N_IN*W  per-requester payload, requester k at bits [k*W +: W]
- io_in_last  in  N_IN  per-requester last-beat-of-burst flag
- io_out_valid  out  1  output stage holds a beat
- io_out_ready  in  1  consumer accepts
- io_out_bits  out  W  registered payload
- io_out_last  out  1  registered last flag
- io_out_chosen  out  CW  registered index of source requester
- io_locked  out  1  arbiter locked to one requester mid-burst

Behaviour:
- Reset (async, reset_n=0): io_out_valid=0, io_out_bits=0, io_out_last=0, io_out_chosen=0, io_locked=0, lock_idx=0, last_grant=N_IN-1 (requester 0 wins first).
- can_load = !io_out_valid | io_out_ready.
- Eligible set:
  - locked: only lock_idx.
  - unlocked: all k with io_in_valid[k].
- Grant (unlocked): first valid index scanning last_grant+1, +2, ... modulo N_IN. Wrap-around is mandatory: last_grant=3 with valid=4'b1001 grants 0.
- Grant (locked): lock_idx if io_in_valid[lock_idx], else none. Other valids are ignored; no grant while the locked requester is idle.
- io_in_ready[k] = can_load & (k == grant index) & a grant exists. Combinational from io_out_ready; at most one bit set.
- Accept = valid & ready on the granted port. On the next edge:
  - out regs load bits, last, and chosen=grant; io_out_valid=1.
  - last_grant = grant.
- If !accept and io_out_ready, then io_out_valid clears next edge.
- Throughput: one beat per cycle when io_out_ready is held high. Latency from input accept to io_out_valid is 1 cycle.
- Output hold: while io_out_valid & !io_out_ready, bits, last and chosen are stable.
- Lock transitions (on accept only):
  - UNLOCKED to LOCKED when the accepted beat has last=0; lock_idx=grant.
  - LOCKED to UNLOCKED when the accepted beat has last=1.
  - A single-beat burst (last=1 while unlocked) never locks.
- io_locked is the registered lock state.
- Simultaneous events: consumer drain and new load in the same cycle are both honoured (stage stays full with the new beat).
- Reset asserted mid-burst: lock is dropped and the buffered beat is discarded immediately. No recovery of partial bursts.

Decomposition:
- Shared package:
  - N_IN/W defaults.
  - A function computing CW.
  - A one-hot-to-index function.
  - A round-robin priority-select function (mask-and-rotate of valid by last_grant) reusable by other arbiters.
- One natural sub-module, rr_pick: combinational.
  - Inputs: request vector, last_grant.
  - Outputs: grant one-hot, grant index, any.
- Lock FSM, output register and ready generation live in the top level.

Test Plan:
- Reset then valid=4'b1111, all last=1, out_ready=1 held → io_out_chosen sequence 0,1,2,3,0 on consecutive cycles starting 1 cycle after first accept; each io_in_ready pulses once per 4 cycles.
- last_grant=2, valid=4'b0011, last=1 → grant 0 then 1. Checks wrap-around; index 3 never granted.
- Requester 1 sends 3-beat burst (bits 0x11,0x22,0x33; last on third) while requester 0 valid throughout → output beats 0x11,0x22,0x33 contiguous from chosen=1, io_locked=1 for those cycles, then requester 0 granted.
- Locked to requester 2, io_in_valid[2] drops for 3 cycles while 0 and 3 valid → no io_in_ready asserted, io_out_valid falls after drain, lock held; resumes on requester 2.
- out_ready=0 for 5 cycles with beat 0xA5 buffered and requester 3 valid → io_out_bits stays 0xA5, io_in_ready=0; out_ready=1 → 0xA5 drains and requester 3's beat loads the same cycle.
- reset_n pulsed low mid-burst (io_locked=1, io_out_valid=1) → outputs zero immediately, asynchronously; after release the first grant is to requester 0 with valid=4'b1111.

Source files
------------

// File: rtl/rr_burst_arbiter_pkg.sv
// rtl/rr_burst_arbiter_pkg.sv - shared types, defaults and round-robin helpers for the burst arbiter
package rr_burst_arbiter_pkg;

    localparam int N_IN_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int MAX_N    = 16;
    localparam int MAX_CW   = 4;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    function automatic int calc_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_CW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_CW-1:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_N; k++) begin
            if (oh[k]) begin
                idx = idx | MAX_CW'(k);
            end
        end
        return idx;
    endfunction

    // Mask off everything at or below last, take the lowest survivor; if none, wrap to lowest overall.
    function automatic logic [MAX_N-1:0] rr_select(input logic [MAX_N-1:0] req,
                                                   input logic [MAX_CW-1:0] last);
        logic [MAX_N-1:0]  upper;
        logic [MAX_N-1:0]  masked;
        logic [MAX_N-1:0]  pick;
        logic [MAX_CW:0]   shamt;
        shamt  = {1'b0, last} + (MAX_CW+1)'(1);
        upper  = {MAX_N{1'b1}} << shamt;
        masked = req & upper;
        if (|masked) begin
            pick = masked & (~masked + MAX_N'(1));
        end else begin
            pick = req & (~req + MAX_N'(1));
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: one-hot grant, index and any-flag
module rr_pick
    import rr_burst_arbiter_pkg::*;
#(
    parameter  int N_IN = N_IN_DEF,
    localparam int CW   = calc_cw(N_IN)
) (
    input  logic [N_IN-1:0] i_req,
    input  logic [CW-1:0]   i_last_grant,
    output logic [N_IN-1:0] o_grant_oh,
    output logic [CW-1:0]   o_grant_idx,
    output logic            o_any
);

    logic [MAX_N-1:0]  w_req_ext;
    logic [MAX_N-1:0]  w_oh_ext;
    logic [MAX_CW-1:0] w_last_ext;
    logic [MAX_CW-1:0] w_idx_ext;
    logic              w_unused_hi;

    assign w_req_ext   = MAX_N'(i_req);
    assign w_last_ext  = MAX_CW'(i_last_grant);
    assign w_oh_ext    = rr_select(w_req_ext, w_last_ext);
    assign w_idx_ext   = onehot_to_idx(w_oh_ext);

    assign o_grant_oh  = w_oh_ext[N_IN-1:0];
    assign o_grant_idx = w_idx_ext[CW-1:0];
    assign o_any       = |i_req;

    // Upper bits are structurally zero for N_IN below the helper width.
    assign w_unused_hi = ^{w_oh_ext, w_idx_ext};

endmodule

// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - round-robin arbiter with burst locking and a registered output stage
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter  int N_IN = N_IN_DEF,
    parameter  int W    = W_DEF,
    localparam int CW   = calc_cw(N_IN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_IN-1:0]   io_in_valid,
    output logic [N_IN-1:0]   io_in_ready,
    input  logic [N_IN*W-1:0] io_in_bits,
    input  logic [N_IN-1:0]   io_in_last,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [W-1:0]      io_out_bits,
    output logic              io_out_last,
    output logic [CW-1:0]     io_out_chosen,
    output logic              io_locked
);

    lock_state_t     r_state;
    logic [CW-1:0]   r_lock_idx;
    logic [CW-1:0]   r_last_grant;
    logic            r_out_valid;
    logic [W-1:0]    r_out_bits;
    logic            r_out_last;
    logic [CW-1:0]   r_out_chosen;

    logic            w_can_load;
    logic [N_IN-1:0] w_lock_mask;
    logic [N_IN-1:0] w_req;
    logic [N_IN-1:0] w_grant_oh;
    logic [CW-1:0]   w_grant_idx;
    logic            w_any;
    logic [N_IN-1:0] w_in_ready;
    logic            w_accept;
    logic [W-1:0]    w_sel_bits;
    logic            w_sel_last;

    assign w_can_load  = !r_out_valid | io_out_ready;

    // While locked only the owning requester may compete, so idle owners stall the channel.
    assign w_lock_mask = N_IN'(1) << r_lock_idx;
    assign w_req       = (r_state == ST_LOCKED) ? (io_in_valid & w_lock_mask) : io_in_valid;

    rr_pick #(
        .N_IN (N_IN)
    ) u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    assign w_in_ready  = (w_can_load && w_any) ? w_grant_oh : '0;
    assign w_accept    = |(io_in_valid & w_in_ready);
    assign w_sel_bits  = io_in_bits[w_grant_idx*W +: W];
    assign w_sel_last  = io_in_last[w_grant_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_UNLOCKED;
            r_lock_idx   <= '0;
            r_last_grant <= CW'(N_IN - 1);
            r_out_valid  <= 1'b0;
            r_out_bits   <= '0;
            r_out_last   <= 1'b0;
            r_out_chosen <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_bits   <= w_sel_bits;
                r_out_last   <= w_sel_last;
                r_out_chosen <= w_grant_idx;
                r_last_grant <= w_grant_idx;
                case (r_state)
                    ST_UNLOCKED: begin
                        if (!w_sel_last) begin
                            r_state    <= ST_LOCKED;
                            r_lock_idx <= w_grant_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_sel_last) begin
                            r_state <= ST_UNLOCKED;
                        end
                    end
                    default: r_state <= ST_UNLOCKED;
                endcase
            end else if (io_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_in_ready   = w_in_ready;
    assign io_out_valid  = r_out_valid;
    assign io_out_bits   = r_out_bits;
    assign io_out_last   = r_out_last;
    assign io_out_chosen = r_out_chosen;
    assign io_locked     = (r_state == ST_LOCKED);

endmodule
